// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core tile sequencer: inst bit map, idle word, FSM states, run config.
package core_ctrl_pkg;

    localparam int unsigned AW     = 11;
    localparam int unsigned INST_W = 34;

    localparam int unsigned ACC_B      = 33;
    localparam int unsigned CEN_P_B    = 32;
    localparam int unsigned WEN_P_B    = 31;
    localparam int unsigned A_P_LSB    = 20;
    localparam int unsigned CEN_X_B    = 19;
    localparam int unsigned WEN_X_B    = 18;
    localparam int unsigned A_X_LSB    = 7;
    localparam int unsigned OFIFO_RD_B = 6;
    localparam int unsigned L0_RD_B    = 3;
    localparam int unsigned L0_WR_B    = 2;
    localparam int unsigned EXEC_B     = 1;
    localparam int unsigned LOAD_B     = 0;

    // Both SRAM chip-enables and write-enables deasserted (active low), everything else 0.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_RD,
        S_W_LOAD,
        S_FLUSH,
        S_X_RD,
        S_EXEC,
        S_DRAIN,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [AW-1:0] w_base;
        logic [AW-1:0] x_base;
        logic [AW-1:0] p_base;
        logic [AW-1:0] len;
        logic          acc;
    } cfg_t;

endpackage

// File: rtl/ctrl_rd_stream.sv
// Base+count address generator; vld is high the cycle after each step (SRAM read latency of 1).
module ctrl_rd_stream
    import core_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          step,
    input  logic [AW-1:0] base,
    output logic [AW-1:0] cnt,
    output logic [AW-1:0] addr_c,
    output logic          vld
);

    logic [AW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;

    always_comb begin
        cnt_d = cnt_q;
        vld_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + AW'(1);
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    // Wraps modulo 2^AW by construction.
    assign addr_c = base + cnt_q;
    assign cnt    = cnt_q;
    assign vld    = vld_q;

endmodule

// File: rtl/core_ctrl.sv
// Tile sequencer driving core's inst bus: kernel load, activation execute, OFIFO drain to pmem.
// Optional CORE_CTRL_PERF_EN adds busy-cycle and drain-stall counters.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned ROW   = 8,
    parameter int unsigned COL   = 8,
    parameter int unsigned FLUSH = ROW + COL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     cfg_w_base,
    input  logic [AW-1:0]     cfg_x_base,
    input  logic [AW-1:0]     cfg_p_base,
    input  logic [AW-1:0]     cfg_len,
    input  logic              cfg_acc,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
`ifdef CORE_CTRL_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall,
`endif
    output logic              done
);

    state_t              state_q, state_d;
    cfg_t                cfg_q, cfg_d;
    logic [AW-1:0]       ph_cnt_q, ph_cnt_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                xs_clr_c, xs_step_c;
    logic [AW-1:0]       xs_base_c, xs_n_c, xs_cnt, xs_addr_c;
    logic                xs_vld;
    logic                ds_clr_c, ds_step_c;
    logic [AW-1:0]       ds_cnt, ds_addr_c;
    logic                ds_vld;

    // One stream serves both xmem read phases; the second counts OFIFO reads, its vld marks pmem writes.
    always_comb begin
        xs_clr_c  = !(state_q == S_W_RD || state_q == S_X_RD);
        xs_base_c = (state_q == S_W_RD) ? cfg_q.w_base : cfg_q.x_base;
        xs_n_c    = (state_q == S_W_RD) ? AW'(ROW) : cfg_q.len;
        xs_step_c = !xs_clr_c && (xs_cnt < xs_n_c);
        ds_clr_c  = (state_q != S_DRAIN);
        ds_step_c = !ds_clr_c && ofifo_valid && (ds_cnt < cfg_q.len);
    end

    ctrl_rd_stream u_xs (
        .clk    (clk),
        .reset  (reset),
        .clr    (xs_clr_c),
        .step   (xs_step_c),
        .base   (xs_base_c),
        .cnt    (xs_cnt),
        .addr_c (xs_addr_c),
        .vld    (xs_vld)
    );

    ctrl_rd_stream u_ds (
        .clk    (clk),
        .reset  (reset),
        .clr    (ds_clr_c),
        .step   (ds_step_c),
        .base   (cfg_q.p_base),
        .cnt    (ds_cnt),
        .addr_c (ds_addr_c),
        .vld    (ds_vld)
    );

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        ph_cnt_d = ph_cnt_q;
        inst_d   = INST_IDLE;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d.w_base = cfg_w_base;
                    cfg_d.x_base = cfg_x_base;
                    cfg_d.p_base = cfg_p_base;
                    cfg_d.len    = cfg_len;
                    cfg_d.acc    = cfg_acc;
                    state_d      = S_W_RD;
                end
            end
            S_W_RD, S_X_RD: begin
                inst_d[CEN_X_B] = !xs_step_c;
                inst_d[WEN_X_B] = 1'b1;
                if (xs_step_c) begin
                    inst_d[A_X_LSB +: AW] = xs_addr_c;
                end
                inst_d[L0_WR_B] = xs_vld;
                if (!xs_step_c) begin
                    state_d = (state_q == S_W_RD) ? S_W_LOAD : S_EXEC;
                end
            end
            S_W_LOAD: begin
                inst_d[LOAD_B]  = 1'b1;
                inst_d[L0_RD_B] = 1'b1;
                if (ph_cnt_q == AW'(COL - 1)) begin
                    ph_cnt_d = '0;
                    state_d  = S_FLUSH;
                end else begin
                    ph_cnt_d = ph_cnt_q + AW'(1);
                end
            end
            S_FLUSH: begin
                if (ph_cnt_q == AW'(FLUSH - 1)) begin
                    ph_cnt_d = '0;
                    state_d  = (cfg_q.len == '0) ? S_FIN : S_X_RD;
                end else begin
                    ph_cnt_d = ph_cnt_q + AW'(1);
                end
            end
            S_EXEC: begin
                inst_d[EXEC_B]  = 1'b1;
                inst_d[L0_RD_B] = 1'b1;
                if (ph_cnt_q == cfg_q.len - AW'(1)) begin
                    ph_cnt_d = '0;
                    state_d  = S_DRAIN;
                end else begin
                    ph_cnt_d = ph_cnt_q + AW'(1);
                end
            end
            S_DRAIN: begin
                inst_d[OFIFO_RD_B] = ds_step_c;
                // The read counter has already advanced past the row being written.
                if (ds_vld) begin
                    inst_d[CEN_P_B]       = 1'b0;
                    inst_d[WEN_P_B]       = 1'b0;
                    inst_d[A_P_LSB +: AW] = ds_addr_c - AW'(1);
                    if (ds_cnt == cfg_q.len) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE) begin
            inst_d[ACC_B] = cfg_q.acc;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cfg_q    <= '0;
            ph_cnt_q <= '0;
            inst_q   <= INST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            ph_cnt_q <= ph_cnt_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef CORE_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Cleared on an accepted start, count while the FSM is out of IDLE, hold afterwards.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                perf_cycles_d = '0;
                perf_stall_d  = '0;
            end
        end else begin
            perf_cycles_d = perf_cycles_q + 32'd1;
            if (state_q == S_DRAIN && !ofifo_valid) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
